// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with an enable prescaler and optional saturation.
// q, tc and sat are all registered; reset is asynchronous and active-high.
module prog_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 0,
    parameter int DIV      = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             sat
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int              WP1      = WIDTH + 1;
    localparam logic [WIDTH:0]  M_EXT    = (MODULO == 0) ? {1'b1, {WIDTH{1'b0}}} : WP1'(MODULO);
    localparam logic [WIDTH:0]  MAX_EXT  = M_EXT - WP1'(1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam bit              SAT_MODE = (SATURATE != 0);

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pre;
    logic             r_tc;
    logic             r_sat;

    logic [WIDTH-1:0] w_q_d;
    logic [PW-1:0]    w_pre_d;
    logic             w_tc_d;
    logic             w_sat_d;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_at_top;
    logic             w_at_bot;

    // Extended-width arithmetic keeps q+1 intact for the modulus compare.
    assign w_inc    = {1'b0, r_q} + WP1'(1);
    assign w_dec    = {1'b0, r_q} - WP1'(1);
    assign w_at_top = ({1'b0, r_q} == MAX_EXT);
    assign w_at_bot = (r_q == '0);

    always_comb begin
        w_q_d   = r_q;
        w_pre_d = r_pre;
        w_tc_d  = 1'b0;
        w_sat_d = r_sat;
        if (clear) begin
            w_q_d   = '0;
            w_pre_d = '0;
            w_sat_d = 1'b0;
        end else if (load) begin
            w_q_d   = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
            w_pre_d = '0;
            w_sat_d = 1'b0;
        end else if (en) begin
            if (r_pre != PRE_LAST) begin
                w_pre_d = r_pre + PW'(1);
            end else begin
                w_pre_d = '0;
                if (up) begin
                    if (w_at_top) begin
                        // At the top bound: either hold and flag, or wrap with a pulse.
                        if (SAT_MODE) begin
                            w_sat_d = 1'b1;
                        end else begin
                            w_q_d  = '0;
                            w_tc_d = 1'b1;
                        end
                    end else begin
                        w_q_d   = w_inc[WIDTH-1:0];
                        w_sat_d = 1'b0;
                        w_tc_d  = SAT_MODE && (w_inc == MAX_EXT);
                    end
                end else begin
                    if (w_at_bot) begin
                        if (SAT_MODE) begin
                            w_sat_d = 1'b1;
                        end else begin
                            w_q_d  = MAX_Q;
                            w_tc_d = 1'b1;
                        end
                    end else begin
                        w_q_d   = w_dec[WIDTH-1:0];
                        w_sat_d = 1'b0;
                        w_tc_d  = SAT_MODE && (w_dec == '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_pre <= '0;
            r_tc  <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            r_q   <= w_q_d;
            r_pre <= w_pre_d;
            r_tc  <= w_tc_d;
            r_sat <= w_sat_d;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign sat = r_sat;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: four parameterisations share one stimulus stream,
// directed scenarios plus a randomized run against a behavioural reference model.
module tb_prog_counter;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       sat;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic [3:0] q [4];
    logic       tc [4];
    logic       sat [4];

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t sb[$];
    obs_t e;
    obs_t a;

    // Reference model state, one slot per DUT.
    int mm[4] = '{10, 16, 10, 10};
    int dv[4] = '{1, 1, 1, 3};
    bit st[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int mq[4];
    int mp[4];
    bit mt[4];
    bit ms[4];

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(0)) d0 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(q[0]), .tc(tc[0]), .sat(sat[0]));
    prog_counter #(.WIDTH(4), .MODULO(0), .DIV(1), .SATURATE(0)) d1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(q[1]), .tc(tc[1]), .sat(sat[1]));
    prog_counter #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(1)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(q[2]), .tc(tc[2]), .sat(sat[2]));
    prog_counter #(.WIDTH(4), .MODULO(10), .DIV(3), .SATURATE(0)) d3 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(q[3]), .tc(tc[3]), .sat(sat[3]));

    task automatic drive(input bit c, input bit l, input logic [3:0] lv, input bit e_i,
                         input bit u);
        @(negedge clk);
        clear    = c;
        load     = l;
        load_val = lv;
        en       = e_i;
        up       = u;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input int i);
        int m;
        m = mm[i];
        mt[i] = 1'b0;
        if (clear) begin
            mq[i] = 0; mp[i] = 0; ms[i] = 1'b0;
        end else if (load) begin
            mq[i] = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
            mp[i] = 0; ms[i] = 1'b0;
        end else if (en) begin
            if (mp[i] < dv[i] - 1) begin
                mp[i]++;
            end else begin
                mp[i] = 0;
                if (up) begin
                    if (mq[i] == m - 1) begin
                        if (st[i]) ms[i] = 1'b1;
                        else begin mq[i] = 0; mt[i] = 1'b1; end
                    end else begin
                        mq[i]++; ms[i] = 1'b0; mt[i] = st[i] && (mq[i] == m - 1);
                    end
                end else begin
                    if (mq[i] == 0) begin
                        if (st[i]) ms[i] = 1'b1;
                        else begin mq[i] = m - 1; mt[i] = 1'b1; end
                    end else begin
                        mq[i]--; ms[i] = 1'b0; mt[i] = st[i] && (mq[i] == 0);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
        #12;
        for (int i = 0; i < 4; i++) begin
            a = {q[i], tc[i], sat[i]};
            n_checks++;
            if (a !== 6'b0) $display("FAIL reset_state dut%0d got %b want 000000", i, a);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        for (int k = 0; k < 12; k++) begin
            e.q = 4'((k + 1) % 10); e.tc = (e.q == 4'd0); e.sat = 1'b0;
            sb.push_back(e);
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            e = sb.pop_front();
            a = {q[0], tc[0], sat[0]};
            n_checks++;
            if (a !== e) $display("FAIL wrap_up step%0d got %b want %b", k, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            e.q = (k == 0) ? 4'd15 : 4'd14; e.tc = (k == 0); e.sat = 1'b0;
            sb.push_back(e);
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            a = {q[1], tc[1], sat[1]};
            n_checks++;
            if (a !== e) $display("FAIL down_wrap step%0d got %b want %b", k, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int  eq[7] = '{7, 8, 9, 9, 9, 9, 8};
        bit  et[7] = '{0, 0, 1, 0, 0, 0, 0};
        bit  es[7] = '{0, 0, 0, 1, 1, 1, 0};
        for (int k = 0; k < 7; k++) begin
            e.q = 4'(eq[k]); e.tc = et[k]; e.sat = es[k];
            sb.push_back(e);
            if (k == 0)      drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
            else if (k < 6)  drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            else             drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            e = sb.pop_front();
            a = {q[2], tc[2], sat[2]};
            n_checks++;
            if (a !== e) $display("FAIL saturate step%0d got %b want %b", k, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_prescale();
        bit ens[4] = '{1, 1, 0, 1};
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e.q = (k == 3) ? 4'd1 : 4'd0; e.tc = 1'b0; e.sat = 1'b0;
            sb.push_back(e);
            drive(1'b0, 1'b0, 4'd0, ens[k], 1'b1);
            e = sb.pop_front();
            a = {q[3], tc[3], sat[3]};
            n_checks++;
            if (a !== e) $display("FAIL prescale cyc%0d got %b want %b", k, a, e);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        n_checks++;
        if (q[3] !== 4'd9) $display("FAIL load_clamp got %0d want 9", q[3]);
        else n_pass++;
        n_checks++;
        if (q[1] !== 4'd12) $display("FAIL load_full_range got %0d want 12", q[1]);
        else n_pass++;
    endtask

    task automatic test_clear_load();
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        n_checks++;
        if (q[0] !== 4'd5) $display("FAIL load5 got %0d want 5", q[0]);
        else n_pass++;
        drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        n_checks++;
        if (q[0] !== 4'd0) $display("FAIL clear_over_load got %0d want 0", q[0]);
        else n_pass++;
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        @(negedge clk);
        load = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({q[0], q[1]} !== 8'h00)
            $display("FAIL async_reset got q0=%0d q1=%0d want 0 0", q[0], q[1]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_prescale();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        @(negedge clk);
        en = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e.q = (k == 2) ? 4'd1 : 4'd0; e.tc = 1'b0; e.sat = 1'b0;
            sb.push_back(e);
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            e = sb.pop_front();
            a = {q[3], tc[3], sat[3]};
            n_checks++;
            if (a !== e) $display("FAIL reset_prescale cyc%0d got %b want %b", k, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0; mp[i] = 0; mt[i] = 1'b0; ms[i] = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            clear    = ($urandom_range(0, 99) < 3);
            load     = ($urandom_range(0, 99) < 6);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) up = ~up;
            for (int i = 0; i < 4; i++) begin
                model_step(i);
                e.q = 4'(mq[i]); e.tc = mt[i]; e.sat = ms[i];
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                e = sb.pop_front();
                a = {q[i], tc[i], sat[i]};
                n_checks++;
                if (a !== e) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random cyc%0d dut%0d got %b want %b", c, i, a, e);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_wrap();
        test_saturate();
        test_prescale();
        test_clear_load();
        test_reset_mid_prescale();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
